// File: rtl/core_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_scheduler: round-robin job dispatch from the input FIFO to NUM_CORES  |
// | hash cores; results are written to the output FIFO in dispatch order.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module core_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int DATA_WIDTH = 256,
    parameter int CIDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic [DATA_WIDTH-1:0]           i_in_fifo_data,
    input  logic                            i_in_fifo_empty,
    output logic                            o_in_fifo_rd_en,
    output logic [NUM_CORES-1:0]            o_core_start,
    output logic [DATA_WIDTH-1:0]           o_core_data,
    input  logic [NUM_CORES-1:0]            i_core_done,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] i_core_result,
    output logic [NUM_CORES-1:0]            o_core_ack,
    output logic                            o_out_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           o_out_fifo_data,
    input  logic                            i_out_fifo_alm_full,
    output logic                            o_idle,
    output logic                            o_error,
    output logic [31:0]                     o_jobs_dispatched,
    output logic [31:0]                     o_jobs_collected
);

    localparam int CNT_W = $clog2(NUM_CORES + 1);

    localparam logic [0:0] D_IDLE  = 1'b0;
    localparam logic [0:0] D_ISSUE = 1'b1;
    localparam logic [0:0] C_IDLE  = 1'b0;
    localparam logic [0:0] C_WRITE = 1'b1;

    logic [0:0]            r_dstate, w_dstate_nxt;
    logic [0:0]            r_cstate, w_cstate_nxt;
    logic [NUM_CORES-1:0]  r_busy, w_busy_nxt;
    logic [CIDX_W-1:0]     r_rr_ptr;
    logic [CIDX_W-1:0]     r_q [NUM_CORES];
    logic [CIDX_W-1:0]     r_head, r_tail;
    logic [CNT_W-1:0]      r_count, w_count_nxt;

    logic                  r_rd_en, r_wr_en, r_idle, r_error;
    logic [NUM_CORES-1:0]  r_start, r_ack;
    logic [DATA_WIDTH-1:0] r_core_data, r_out_data;
    logic [31:0]           r_disp, r_coll;

    logic                  w_sel_found;
    logic [CIDX_W-1:0]     w_sel;
    logic [CIDX_W-1:0]     w_head_core;
    logic [NUM_CORES-1:0]  w_sel_oh, w_head_oh;
    logic                  w_dispatch, w_collect, w_retire, w_done_err, w_idle_nxt;

    function automatic logic [CIDX_W-1:0] f_inc(input logic [CIDX_W-1:0] p);
        if (int'(p) == NUM_CORES - 1) return '0;
        return p + 1'b1;
    endfunction

    // First free core at or after the round-robin pointer, wrapping.
    always_comb begin
        int                v_idx;
        logic [CIDX_W-1:0] v_cidx;
        w_sel_found = 1'b0;
        w_sel       = '0;
        v_idx       = 0;
        v_cidx      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            v_idx  = (int'(r_rr_ptr) + i) % NUM_CORES;
            v_cidx = v_idx[CIDX_W-1:0];
            if (!w_sel_found && !r_busy[v_cidx]) begin
                w_sel_found = 1'b1;
                w_sel       = v_cidx;
            end
        end
    end

    always_comb begin
        w_dstate_nxt = r_dstate;
        case (r_dstate)
            D_IDLE:  if (w_dispatch) w_dstate_nxt = D_ISSUE;
            D_ISSUE: w_dstate_nxt = D_IDLE;
            default: w_dstate_nxt = D_IDLE;
        endcase
        w_cstate_nxt = r_cstate;
        case (r_cstate)
            C_IDLE:  if (w_collect) w_cstate_nxt = C_WRITE;
            C_WRITE: w_cstate_nxt = C_IDLE;
            default: w_cstate_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        w_head_core = r_q[r_head];
        w_dispatch  = (r_dstate == D_IDLE) && i_enable && !i_in_fifo_empty && w_sel_found;
        w_collect   = (r_cstate == C_IDLE) && (r_count != '0) && i_core_done[w_head_core]
                      && !i_out_fifo_alm_full;
        w_retire    = (r_cstate == C_WRITE);
        w_done_err  = (r_cstate == C_IDLE) && (|(i_core_done & ~r_busy));

        w_sel_oh            = '0;
        w_sel_oh[w_sel]     = w_dispatch;
        w_head_oh           = '0;
        w_head_oh[w_head_core] = 1'b1;

        w_busy_nxt = (r_busy | w_sel_oh) & ~(w_retire ? w_head_oh : '0);

        w_count_nxt = r_count;
        if (w_dispatch && !w_retire)
            w_count_nxt = r_count + 1'b1;
        else if (!w_dispatch && w_retire)
            w_count_nxt = r_count - 1'b1;

        w_idle_nxt = (w_busy_nxt == '0) && (w_count_nxt == '0);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dstate    <= D_IDLE;
            r_cstate    <= C_IDLE;
            r_busy      <= '0;
            r_rr_ptr    <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_rd_en     <= 1'b0;
            r_start     <= '0;
            r_core_data <= '0;
            r_wr_en     <= 1'b0;
            r_ack       <= '0;
            r_out_data  <= '0;
            r_idle      <= 1'b1;
            r_error     <= 1'b0;
            r_disp      <= '0;
            r_coll      <= '0;
        end else begin
            r_dstate <= w_dstate_nxt;
            r_cstate <= w_cstate_nxt;
            r_busy   <= w_busy_nxt;
            r_count  <= w_count_nxt;
            r_idle   <= w_idle_nxt;
            r_rd_en  <= w_dispatch;
            r_start  <= w_sel_oh;
            r_wr_en  <= w_collect;
            r_ack    <= w_collect ? w_head_oh : '0;
            if (w_dispatch) begin
                r_core_data <= i_in_fifo_data;
                r_tail      <= f_inc(r_tail);
                r_rr_ptr    <= f_inc(w_sel);
                r_disp      <= r_disp + 32'd1;
            end
            if (w_collect)
                r_out_data <= i_core_result[w_head_core*DATA_WIDTH +: DATA_WIDTH];
            if (w_retire) begin
                r_head <= f_inc(r_head);
                r_coll <= r_coll + 32'd1;
            end
            if (w_done_err)
                r_error <= 1'b1;
        end
    end

    // Queue storage needs no reset: entries are only read while count > 0.
    always_ff @(posedge i_clk) begin
        if (w_dispatch)
            r_q[r_tail] <= w_sel;
    end

    assign o_in_fifo_rd_en   = r_rd_en;
    assign o_core_start      = r_start;
    assign o_core_data       = r_core_data;
    assign o_core_ack        = r_ack;
    assign o_out_fifo_wr_en  = r_wr_en;
    assign o_out_fifo_data   = r_out_data;
    assign o_idle            = r_idle;
    assign o_error           = r_error;
    assign o_jobs_dispatched = r_disp;
    assign o_jobs_collected  = r_coll;

endmodule
`default_nettype wire

// File: tb/tb_core_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_core_scheduler: randomized bench with host FIFO, core and order models. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_core_scheduler;

    localparam int NC = 4;
    localparam int DW = 256;
    localparam logic [DW-1:0] C_MASK = {8{32'hC0DE_5A5A}};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_empty = 1'b1;
    logic              rd_en;
    logic [NC-1:0]     start;
    logic [DW-1:0]     core_data;
    logic [NC-1:0]     c_done_v = '0;
    logic [NC-1:0]     force_done = '0;
    logic [NC-1:0]     core_done;
    logic [NC*DW-1:0]  core_result = '0;
    logic [NC-1:0]     ack;
    logic              wr_en;
    logic [DW-1:0]     out_data;
    logic              alm_full = 1'b0;
    logic              idle, error;
    logic [31:0]       disp, coll;

    assign core_done = c_done_v | force_done;

    always #5 clk = ~clk;

    core_scheduler #(.NUM_CORES(NC), .DATA_WIDTH(DW)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_enable(enable),
        .i_in_fifo_data(in_data), .i_in_fifo_empty(in_empty), .o_in_fifo_rd_en(rd_en),
        .o_core_start(start), .o_core_data(core_data),
        .i_core_done(core_done), .i_core_result(core_result), .o_core_ack(ack),
        .o_out_fifo_wr_en(wr_en), .o_out_fifo_data(out_data),
        .i_out_fifo_alm_full(alm_full), .o_idle(idle), .o_error(error),
        .o_jobs_dispatched(disp), .o_jobs_collected(coll)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic t_check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Host-side view: jobs written, results expected in the same order.
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] exp_q[$];
    int            ord_q[$];
    int            start_cyc[$];
    int            wr_cyc[$];
    int            n_pushed = 0;
    int            cyc = 0;

    // Scheduler-rule model and simple core models.
    bit            m_busy[NC];
    bit            pend_clr[NC];
    int            m_rr = 0;
    bit            c_busy[NC];
    bit            c_done[NC];
    int            c_cnt[NC];
    logic [DW-1:0] c_res[NC];
    int            lat_fix[NC];
    bit            use_fix = 1'b0;

    function automatic logic [DW-1:0] f_result(input logic [DW-1:0] job);
        return job ^ C_MASK;
    endfunction

    always @(negedge clk) begin : p_model
        int sel;
        int pred;
        int a;
        if (rst) begin
            in_q.delete(); exp_q.delete(); ord_q.delete();
            m_rr = 0;
            for (int n = 0; n < NC; n++) begin
                m_busy[n] = 0; pend_clr[n] = 0; c_busy[n] = 0; c_done[n] = 0; c_cnt[n] = 0;
            end
        end else begin
            cyc++;
            if (rd_en || start != '0) begin
                t_check("rd_en_with_start", DW'(rd_en), DW'(|start));
                t_check("start_onehot", DW'($countones(start)), DW'(1));
                sel = 0;
                for (int n = NC - 1; n >= 0; n--) if (start[n]) sel = n;
                pred = NC;
                for (int i = 0; i < NC; i++)
                    if (pred == NC && !m_busy[(m_rr + i) % NC]) pred = (m_rr + i) % NC;
                t_check("start_core", DW'(sel), DW'(pred));
                if (in_q.size() > 0) begin
                    t_check("core_data", core_data, in_q[0]);
                    void'(in_q.pop_front());
                end else begin
                    t_check("start_with_empty_fifo", DW'(0), DW'(1));
                end
                m_busy[sel] = 1;
                m_rr = (sel + 1) % NC;
                ord_q.push_back(sel);
                start_cyc.push_back(cyc);
                c_busy[sel] = 1;
                c_done[sel] = 0;
                c_cnt[sel]  = use_fix ? lat_fix[sel] : int'($urandom_range(1, 15));
                c_res[sel]  = f_result(core_data);
            end
            for (int n = 0; n < NC; n++) begin
                if (pend_clr[n]) m_busy[n] = 0;
                pend_clr[n] = 0;
            end
            if (wr_en || ack != '0) begin
                t_check("wr_en_with_ack", DW'(wr_en), DW'(|ack));
                t_check("ack_onehot", DW'($countones(ack)), DW'(1));
                a = 0;
                for (int n = NC - 1; n >= 0; n--) if (ack[n]) a = n;
                if (ord_q.size() > 0) t_check("ack_core_order", DW'(a), DW'(ord_q.pop_front()));
                else                  t_check("ack_without_job", DW'(0), DW'(1));
                if (exp_q.size() > 0) t_check("out_data_order", out_data, exp_q.pop_front());
                else                  t_check("write_without_job", DW'(0), DW'(1));
                wr_cyc.push_back(cyc);
                pend_clr[a] = 1;
                c_busy[a] = 0;
                c_done[a] = 0;
            end
            for (int n = 0; n < NC; n++) begin
                if (c_busy[n] && !c_done[n]) begin
                    if (c_cnt[n] > 0) c_cnt[n]--;
                    if (c_cnt[n] == 0) c_done[n] = 1;
                end
            end
        end
        for (int n = 0; n < NC; n++) begin
            c_done_v[n] = c_done[n];
            core_result[n*DW +: DW] = c_res[n];
        end
        in_empty = (in_q.size() == 0);
        in_data  = in_empty ? '0 : in_q[0];
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_job();
        logic [DW-1:0] j;
        for (int k = 0; k < DW / 32; k++) j[k*32 +: 32] = $urandom();
        in_q.push_back(j);
        exp_q.push_back(f_result(j));
        n_pushed++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && k < 3000) begin
            step(1);
            k++;
        end
        t_check("drain_in_budget", DW'(k < 3000), DW'(1));
        step(3);
        t_check("idle_after_drain", DW'(idle), DW'(1));
        t_check("dispatched_count", DW'(disp), DW'(n_pushed));
        t_check("collected_count", DW'(coll), DW'(n_pushed));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        n_pushed = 0;
        step(1);
    endtask

    initial begin
        int k;
        int base_d;
        int base_c;
        for (int n = 0; n < NC; n++) begin
            c_res[n] = '0; lat_fix[n] = 1;
        end
        #2 rst = 1'b1;
        step(2);
        t_check("rst_idle", DW'(idle), DW'(1));
        t_check("rst_error", DW'(error), DW'(0));
        t_check("rst_start", DW'(start), DW'(0));
        t_check("rst_rd_en", DW'(rd_en), DW'(0));
        t_check("rst_wr_en", DW'(wr_en), DW'(0));
        t_check("rst_ack", DW'(ack), DW'(0));
        t_check("rst_disp", DW'(disp), DW'(0));
        t_check("rst_coll", DW'(coll), DW'(0));
        t_check("rst_core_data", core_data, '0);
        t_check("rst_out_data", out_data, '0);
        rst = 1'b0;
        enable = 1'b1;
        step(1);

        // Asynchronous reset while a start pulse is high.
        push_job();
        step(1);
        t_check("pre_rst_start", DW'(start), DW'(4'b0001));
        t_check("pre_rst_rd_en", DW'(rd_en), DW'(1));
        rst = 1'b1;
        #1;
        t_check("async_rst_start", DW'(start), DW'(0));
        t_check("async_rst_rd_en", DW'(rd_en), DW'(0));
        t_check("async_rst_idle", DW'(idle), DW'(1));
        step(2);
        rst = 1'b0;
        n_pushed = 0;
        step(1);

        // Five jobs; cores finish 2,0,3,1 but writes must follow 0,1,2,3.
        use_fix = 1'b1;
        lat_fix[0] = 12; lat_fix[1] = 20; lat_fix[2] = 4; lat_fix[3] = 10;
        start_cyc.delete(); wr_cyc.delete();
        base_c = cyc;
        for (int i = 0; i < 5; i++) push_job();
        k = 0;
        while (start_cyc.size() < 4 && k < 50) begin step(1); k++; end
        t_check("four_starts_seen", DW'(start_cyc.size() >= 4), DW'(1));
        step(3);
        t_check("fifth_held_disp", DW'(disp), DW'(4));
        t_check("fifth_held_fifo", DW'(in_q.size()), DW'(1));
        drain();
        if (start_cyc.size() >= 5 && wr_cyc.size() >= 1) begin
            t_check("first_start_latency", DW'(start_cyc[0] - base_c), DW'(2));
            for (int i = 0; i < 3; i++)
                t_check("start_spacing", DW'(start_cyc[i+1] - start_cyc[i]), DW'(2));
            t_check("fifth_after_write", DW'(start_cyc[4] > wr_cyc[0]), DW'(1));
        end else begin
            t_check("burst_event_count", DW'(start_cyc.size()), DW'(5));
        end

        // Output FIFO almost full holds all results until released.
        for (int n = 0; n < NC; n++) lat_fix[n] = 2;
        alm_full = 1'b1;
        wr_cyc.delete();
        for (int i = 0; i < 4; i++) push_job();
        step(30);
        t_check("alm_full_no_write", DW'(wr_cyc.size()), DW'(0));
        t_check("alm_full_dispatch", DW'(disp), DW'(n_pushed));
        t_check("alm_full_all_done", DW'(core_done), DW'(4'hF));
        alm_full = 1'b0;
        drain();
        if (wr_cyc.size() == 4) begin
            for (int i = 0; i < 3; i++)
                t_check("write_spacing", DW'(wr_cyc[i+1] - wr_cyc[i]), DW'(2));
        end else begin
            t_check("alm_release_writes", DW'(wr_cyc.size()), DW'(4));
        end

        // Disable with jobs pending; in-flight work still collected.
        for (int n = 0; n < NC; n++) lat_fix[n] = 8;
        base_d = int'(disp);
        base_c = int'(coll);
        push_job(); push_job();
        k = 0;
        while (int'(disp) < base_d + 2 && k < 50) begin step(1); k++; end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push_job();
        step(40);
        t_check("disabled_no_dispatch", DW'(disp), DW'(base_d + 2));
        t_check("disabled_fifo_kept", DW'(in_q.size()), DW'(3));
        t_check("disabled_collects", DW'(coll), DW'(base_c + 2));
        enable = 1'b1;
        drain();

        // Randomized traffic with enable and back-pressure toggling.
        use_fix = 1'b0;
        k = 0;
        for (int i = 0; i < 400; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            alm_full = ($urandom_range(0, 4) == 0);
            if (k < 60 && $urandom_range(0, 2) == 0) begin
                push_job();
                k++;
            end
            step(1);
        end
        enable = 1'b1;
        alm_full = 1'b0;
        drain();
        t_check("no_error_in_traffic", DW'(error), DW'(0));

        // Done from an idle core is sticky until reset.
        force_done[3] = 1'b1;
        step(2);
        t_check("error_set", DW'(error), DW'(1));
        force_done[3] = 1'b0;
        step(5);
        t_check("error_sticky", DW'(error), DW'(1));
        do_reset();
        t_check("error_cleared_by_reset", DW'(error), DW'(0));
        t_check("idle_after_reset", DW'(idle), DW'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
